// File: rtl/twiddle_seq_pkg.sv
// -----------------------------------------------------------------------------
// twiddle_seq_pkg
// Shared definitions for the twiddle-factor sequencer:
//   - QM_TABLE   : quarter -> index multiplier {0, 2, 1, 3}
//   - octant_e   : encoding of the top three table-address bits
//   - c_const()  : round(cos(pi/4) * 2^(WIDTH-1))
//   - s_const()  : -2^(WIDTH-1)
//   - tw_re_of() / tw_im_of() : elaboration-time table generators giving
//     round(cos(2*pi*a/N)*2^(WIDTH-1)) and -round(sin(2*pi*a/N)*2^(WIDTH-1)),
//     both saturated to WIDTH bits. They are used only in constant contexts.
// -----------------------------------------------------------------------------
package twiddle_seq_pkg;

    localparam logic [1:0] QM_TABLE [4] = '{2'd0, 2'd2, 2'd1, 2'd3};

    typedef enum logic [2:0] {
        OCT_0 = 3'd0,
        OCT_1 = 3'd1,
        OCT_2 = 3'd2,
        OCT_3 = 3'd3,
        OCT_4 = 3'd4,
        OCT_5 = 3'd5,
        OCT_6 = 3'd6,
        OCT_7 = 3'd7
    } octant_e;

    localparam real PI = 3.14159265358979323846;

    function automatic real pow2_r(input int e);
        real r;
        r = 1.0;
        for (int i = 0; i < e; i++) r = r * 2.0;
        return r;
    endfunction

    // Arguments arrive in [0, 2*pi); folding into [-pi, pi] keeps the
    // Taylor series well inside double precision.
    function automatic real fold_r(input real x);
        return (x > PI) ? x - 2.0 * PI : x;
    endfunction

    function automatic real cos_r(input real x);
        real xr, term, sum;
        xr   = fold_r(x);
        term = 1.0;
        sum  = 1.0;
        for (int n = 1; n <= 24; n++) begin
            term = -term * xr * xr / $itor((2 * n - 1) * (2 * n));
            sum  = sum + term;
        end
        return sum;
    endfunction

    function automatic real sin_r(input real x);
        real xr, term, sum;
        xr   = fold_r(x);
        term = xr;
        sum  = xr;
        for (int n = 1; n <= 24; n++) begin
            term = -term * xr * xr / $itor((2 * n) * (2 * n + 1));
            sum  = sum + term;
        end
        return sum;
    endfunction

    // Round half away from zero, then clamp to the signed WIDTH range.
    function automatic int round_sat(input real x, input int width);
        int r, hi, lo;
        hi = (1 << (width - 1)) - 1;
        lo = -(1 << (width - 1));
        r  = (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(0.5 - x);
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return r;
    endfunction

    function automatic int tw_re_of(input int a, input int nn, input int width);
        return round_sat(cos_r(2.0 * PI * $itor(a) / pow2_r(nn)) * pow2_r(width - 1), width);
    endfunction

    function automatic int tw_im_of(input int a, input int nn, input int width);
        return round_sat(-sin_r(2.0 * PI * $itor(a) / pow2_r(nn)) * pow2_r(width - 1), width);
    endfunction

    function automatic int c_const(input int width);
        return round_sat(cos_r(PI / 4.0) * pow2_r(width - 1), width);
    endfunction

    function automatic int s_const(input int width);
        return -(1 << (width - 1));
    endfunction

endpackage

// File: rtl/twiddle_seq_if.sv
// -----------------------------------------------------------------------------
// twiddle_seq_if
// Data-side bundle of the twiddle sequencer.
//   di_en     : one data sample accepted this cycle (driven by master)
//   do_en     : twiddle outputs valid this cycle
//   tw_bypass : twiddle is exactly 1+j0
//   tw_re     : twiddle real part, Q1.(WIDTH-1)
//   tw_im     : twiddle imaginary part, Q1.(WIDTH-1)
// Modports: master = sample source / twiddle consumer, slave = twiddle_seq.
// -----------------------------------------------------------------------------
interface twiddle_seq_if #(
    parameter int WIDTH = 16
) ();

    logic             di_en;
    logic             do_en;
    logic             tw_bypass;
    logic [WIDTH-1:0] tw_re;
    logic [WIDTH-1:0] tw_im;

    modport master (
        output di_en,
        input  do_en,
        input  tw_bypass,
        input  tw_re,
        input  tw_im
    );

    modport slave (
        input  di_en,
        output do_en,
        output tw_bypass,
        output tw_re,
        output tw_im
    );

endinterface

// File: rtl/twiddle_rom.sv
// -----------------------------------------------------------------------------
// twiddle_rom
// Constant twiddle table with a registered read port (one cycle latency).
// Entry a holds round(cos(2*pi*a/N)*2^(WIDTH-1)) and
// -round(sin(2*pi*a/N)*2^(WIDTH-1)), N = 2^NN, saturated to WIDTH bits.
// DEPTH is chosen by the parent: 2^NN for the full table, 2^NN/8+1 when
// TWIDDLE_TAB_REDUCE_EN is defined.
// Ports:
//   clock  : read clock
//   addr_i : table address
//   re_o   : registered real part
//   im_o   : registered imaginary part
// -----------------------------------------------------------------------------
module twiddle_rom
    import twiddle_seq_pkg::*;
#(
    parameter int NN    = 6,
    parameter int WIDTH = 16,
    parameter int DEPTH = 1 << NN,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic [AW-1:0]    addr_i,
    output logic [WIDTH-1:0] re_o,
    output logic [WIDTH-1:0] im_o
);

    localparam int TAB_SIZE = 1 << AW;

    logic [WIDTH-1:0] tab_re [TAB_SIZE];
    logic [WIDTH-1:0] tab_im [TAB_SIZE];

    // Unused slots past DEPTH (non-power-of-two depth) read as zero.
    for (genvar a = 0; a < TAB_SIZE; a++) begin : g_tab
        if (a < DEPTH) begin : g_used
            localparam int RE_I = tw_re_of(a, NN, WIDTH);
            localparam int IM_I = tw_im_of(a, NN, WIDTH);
            assign tab_re[a] = RE_I[WIDTH-1:0];
            assign tab_im[a] = IM_I[WIDTH-1:0];
        end else begin : g_pad
            assign tab_re[a] = '0;
            assign tab_im[a] = '0;
        end
    end

    // NOTE: the read register has no reset; the valid bit that travels
    // alongside in the parent qualifies its contents.
    always_ff @(posedge clock) begin
        re_o <= tab_re[addr_i];
        im_o <= tab_im[addr_i];
    end

endmodule

// File: rtl/twiddle_seq.sv
// -----------------------------------------------------------------------------
// twiddle_seq
// Generates one twiddle factor per accepted sample for a radix stage of
// block size M = 2^LOG_M inside an N = 2^NN point FFT.
//   S1: sample counter -> table address (k*qm) << (NN-LOG_M), valid bit
//   S2: registered ROM read, address and valid carried alongside
//   S3: octant reconstruction / bypass detection, output registers
// Latency is 3 cycles, one output per input.
// Build option: define TWIDDLE_TAB_REDUCE_EN to store only the first octant
// (N/8+1 entries) and rebuild the rest by symmetry; outputs are identical.
// Ports:
//   clock : rising-edge clock
//   reset : asynchronous, active-high reset
//   bus   : twiddle_seq_if.slave (di_en in; do_en, tw_bypass, tw_re, tw_im out)
// -----------------------------------------------------------------------------
module twiddle_seq
    import twiddle_seq_pkg::*;
#(
    parameter int NN    = 6,
    parameter int LOG_M = 6,
    parameter int WIDTH = 16
) (
    input  logic         clock,
    input  logic         reset,
    twiddle_seq_if.slave bus
);

`ifdef TWIDDLE_TAB_REDUCE_EN
    localparam int ROM_DEPTH = (1 << NN) / 8 + 1;
`else
    localparam int ROM_DEPTH = 1 << NN;
`endif
    localparam int ROM_AW = $clog2(ROM_DEPTH);

    // ---------------- S1: counter and address ----------------
    logic [LOG_M-1:0] cnt_q, cnt_d;
    logic [1:0]       quarter;
    logic [LOG_M-3:0] k_idx;
    logic [LOG_M-1:0] prod;
    logic [NN-1:0]    taddr_d;

    logic             s1_valid_q;
    logic [NN-1:0]    s1_taddr_q;
    logic             s2_valid_q;
    logic [NN-1:0]    s2_taddr_q;

    logic             do_en_q;
    logic             tw_bypass_q, tw_bypass_d;
    logic [WIDTH-1:0] tw_re_q, tw_re_d;
    logic [WIDTH-1:0] tw_im_q, tw_im_d;

    // The address is built from the count before this cycle's increment.
    // The product never reaches M, so the LOG_M-bit multiply is exact.
    always_comb begin
        cnt_d   = bus.di_en ? cnt_q + LOG_M'(1) : cnt_q;
        quarter = cnt_q[LOG_M-1:LOG_M-2];
        k_idx   = cnt_q[LOG_M-3:0];
        prod    = LOG_M'(k_idx) * LOG_M'(QM_TABLE[quarter]);
        taddr_d = NN'(prod) << (NN - LOG_M);
    end

    // ---------------- S2: table read ----------------
    logic [ROM_AW-1:0] rom_addr;
    logic [WIDTH-1:0]  rom_re, rom_im;

`ifdef TWIDDLE_TAB_REDUCE_EN
    localparam int OCT_LEN = (1 << NN) / 8;

    // Odd octants run backwards through the stored octant.
    always_comb begin
        if (s1_taddr_q[NN-3]) begin
            rom_addr = ROM_AW'(OCT_LEN - int'(s1_taddr_q[NN-4:0]));
        end else begin
            rom_addr = ROM_AW'(s1_taddr_q[NN-4:0]);
        end
    end
`else
    assign rom_addr = s1_taddr_q;
`endif

    twiddle_rom #(
        .NN    (NN),
        .WIDTH (WIDTH),
        .DEPTH (ROM_DEPTH)
    ) u_rom (
        .clock  (clock),
        .addr_i (rom_addr),
        .re_o   (rom_re),
        .im_o   (rom_im)
    );

    // ---------------- S3: reconstruction ----------------
`ifdef TWIDDLE_TAB_REDUCE_EN
    localparam int               C_I     = c_const(WIDTH);
    localparam int               S_I     = s_const(WIDTH);
    localparam logic [WIDTH-1:0] C_W     = C_I[WIDTH-1:0];
    localparam logic [WIDTH-1:0] NEG_C_W = -C_W;
    localparam logic [WIDTH-1:0] S_W     = S_I[WIDTH-1:0];

    octant_e octant;
    logic    on_axis;
`endif

    // NOTE: every output of this block gets a default first so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        tw_bypass_d = (s2_taddr_q == '0);
        tw_re_d     = rom_re;
        tw_im_d     = rom_im;
`ifdef TWIDDLE_TAB_REDUCE_EN
        octant  = octant_e'(s2_taddr_q[NN-1:NN-3]);
        on_axis = (s2_taddr_q[NN-4:0] == '0);
        // Octant boundaries use exact constants: the stored entry 0 is the
        // saturated +1, which would be off by one LSB where -1 is needed.
        case (octant)
            OCT_1: begin
                tw_re_d = on_axis ? C_W     : -rom_im;
                tw_im_d = on_axis ? NEG_C_W : -rom_re;
            end
            OCT_2: begin
                tw_re_d = on_axis ? '0  : rom_im;
                tw_im_d = on_axis ? S_W : -rom_re;
            end
            OCT_3: begin
                tw_re_d = on_axis ? NEG_C_W : -rom_re;
                tw_im_d = on_axis ? NEG_C_W : rom_im;
            end
            OCT_4: begin
                tw_re_d = on_axis ? S_W : -rom_re;
                tw_im_d = on_axis ? '0  : -rom_im;
            end
            OCT_5: begin
                tw_re_d = rom_im;
                tw_im_d = rom_re;
            end
            default: begin
                tw_re_d = rom_re;
                tw_im_d = rom_im;
            end
        endcase
`endif
        // Address 0 is flagged as a pass-through and carries zero data.
        if (tw_bypass_d) begin
            tw_re_d = '0;
            tw_im_d = '0;
        end
    end

    // ---------------- state ----------------
    // NOTE: non-blocking assignments make each stage capture the value its
    // predecessor held before the edge, independent of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            s1_taddr_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_taddr_q  <= '0;
            do_en_q     <= 1'b0;
            tw_bypass_q <= 1'b0;
            tw_re_q     <= '0;
            tw_im_q     <= '0;
        end else begin
            cnt_q      <= cnt_d;
            s1_valid_q <= bus.di_en;
            s1_taddr_q <= taddr_d;
            s2_valid_q <= s1_valid_q;
            s2_taddr_q <= s1_taddr_q;
            do_en_q    <= s2_valid_q;
            // Outputs hold their last value between valid entries.
            if (s2_valid_q) begin
                tw_bypass_q <= tw_bypass_d;
                tw_re_q     <= tw_re_d;
                tw_im_q     <= tw_im_d;
            end
        end
    end

    assign bus.do_en     = do_en_q;
    assign bus.tw_bypass = tw_bypass_q;
    assign bus.tw_re     = tw_re_q;
    assign bus.tw_im     = tw_im_q;

endmodule

// File: tb/tb_twiddle_seq.sv
// -----------------------------------------------------------------------------
// tb_twiddle_seq
// Self-checking bench for twiddle_seq (NN=6, LOG_M=6, WIDTH=16).
// The reference model derives each expected twiddle straight from the
// sample index: taddr = (k*qm) << (NN-LOG_M), value = exp(-j*2*pi*taddr/N)
// rounded to Q1.15, with a fixed 3-entry delay queue for the latency.
// Works unchanged against either TWIDDLE_TAB_REDUCE_EN build.
// -----------------------------------------------------------------------------
module tb_twiddle_seq;

    localparam int  NN    = 6;
    localparam int  LOG_M = 6;
    localparam int  WIDTH = 16;
    localparam int  N     = 1 << NN;
    localparam int  M     = 1 << LOG_M;
    localparam real PI_R  = 3.14159265358979323846;
    localparam int  QM_REF [4] = '{0, 2, 1, 3};

    typedef struct {
        bit valid;
        int cnt;
        int taddr;
    } entry_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    twiddle_seq_if #(.WIDTH(WIDTH)) bus ();

    twiddle_seq #(
        .NN    (NN),
        .LOG_M (LOG_M),
        .WIDTH (WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int               m_cnt;
    entry_t           pipe [$];
    logic             exp_byp;
    logic [WIDTH-1:0] exp_re;
    logic [WIDTH-1:0] exp_im;
    int               cyc;
    bit               lat_chk;
    bit               post_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s @%0t: got 0x%0h, want 0x%0h", tag, $time, got, want);
        end
    endtask

    function automatic logic [WIDTH-1:0] to_q(input real x);
        real y;
        int  r;
        y = x * 32768.0;
        r = (y >= 0.0) ? $rtoi(y + 0.5) : -$rtoi(0.5 - y);
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r[WIDTH-1:0];
    endfunction

    function automatic int taddr_of(input int c);
        int q, k;
        q = c / (M / 4);
        k = c % (M / 4);
        return (k * QM_REF[q]) << (NN - LOG_M);
    endfunction

    task automatic model_reset();
        entry_t idle;
        idle.valid = 1'b0;
        idle.cnt   = 0;
        idle.taddr = 0;
        m_cnt   = 0;
        pipe.delete();
        pipe.push_back(idle);
        pipe.push_back(idle);
        exp_byp = 1'b0;
        exp_re  = '0;
        exp_im  = '0;
        cyc     = 0;
    endtask

    // Present one cycle of di_en, advance one clock, check at the falling edge.
    task automatic tick(input bit en);
        entry_t e, o;
        real    ang;
        e.valid   = en;
        e.cnt     = m_cnt;
        e.taddr   = taddr_of(m_cnt);
        bus.di_en = en;
        pipe.push_back(e);
        if (en) m_cnt = (m_cnt + 1) % M;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        o = pipe.pop_front();
        if (o.valid) begin
            exp_byp = (o.taddr == 0);
            if (exp_byp) begin
                exp_re = '0;
                exp_im = '0;
            end else begin
                ang    = 2.0 * PI_R * $itor(o.taddr) / $itor(N);
                exp_re = to_q($cos(ang));
                exp_im = to_q(-$sin(ang));
            end
        end
        check("do_en", bus.do_en, o.valid);
        check("tw_bypass", bus.tw_bypass, exp_byp);
        check("tw_re", bus.tw_re, exp_re);
        check("tw_im", bus.tw_im, exp_im);
        if (lat_chk) check("latency_window", bus.do_en, (cyc >= 3 && cyc <= 66));
        if (o.valid) begin
            if (o.cnt < 16 || o.cnt % 16 == 0) check("bypass_sample", bus.tw_bypass, 1'b1);
            case (o.cnt)
                20: begin
                    check("s20_re", bus.tw_re, 16'h5A82);
                    check("s20_im", bus.tw_im, 16'hA57E);
                end
                24: begin
                    check("s24_re", bus.tw_re, 16'h0000);
                    check("s24_im", bus.tw_im, 16'h8000);
                end
                52: begin
                    check("s52_re", bus.tw_re, 16'h30FC);
                    check("s52_im", bus.tw_im, 16'h89BE);
                end
                default: ;
            endcase
            if (post_rst) begin
                check("post_reset_bypass", bus.tw_bypass, 1'b1);
                post_rst = 1'b0;
            end
        end
    endtask

    // Called with the clock low; checks the asynchronous clear before any edge.
    task automatic pulse_reset();
        reset     = 1'b1;
        bus.di_en = 1'b0;
        #1;
        check("rst_do_en", bus.do_en, 1'b0);
        check("rst_bypass", bus.tw_bypass, 1'b0);
        check("rst_tw_re", bus.tw_re, '0);
        check("rst_tw_im", bus.tw_im, '0);
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        bus.di_en = 1'b0;
        lat_chk   = 1'b0;
        post_rst  = 1'b0;
        model_reset();
        @(negedge clock);
        pulse_reset();

        // One full block back to back, then drain.
        lat_chk = 1'b1;
        for (int i = 0; i < 68; i++) tick(i < 64);
        lat_chk = 1'b0;

        // Sparse 1,0,0,1 pattern across more than one counter wrap.
        for (int i = 0; i < 45; i++) begin
            tick(1'b1);
            tick(1'b0);
            tick(1'b0);
            tick(1'b1);
        end

        // Run up to sample 37, then reset with entries in flight.
        for (int i = 0; i < M && m_cnt != 37; i++) tick(1'b1);
        tick(1'b1);
        pulse_reset();
        post_rst = 1'b1;
        tick(1'b0);
        for (int i = 0; i < 10; i++) tick(1'b1);

        // Random gaps with an occasional reset.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                pulse_reset();
                post_rst = 1'b1;
            end
            tick($urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 4; i++) tick(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/twiddle_seq.md
TWIDDLE_SEQ -- requirements
Module: twiddle_seq

Interface
REQ-001 Parameters SHALL be:
- NN, 6, log2 of FFT size N; table address width.
- LOG_M, 6, log2 of this stage's block size M, with 3 <= LOG_M <= NN.
- WIDTH, 16, twiddle word length.
REQ-002 Ports SHALL be, clock and reset first:
- clock, in, 1: single clock; all state updates on the rising edge.
- reset, in, 1: asynchronous, active-high reset.
- di_en, in, 1: one data sample accepted this cycle.
- do_en, out, 1: twiddle outputs valid this cycle.
- tw_bypass, out, 1: twiddle is exactly 1+j0; the multiplier passes data through.
- tw_re, out, WIDTH: twiddle real part, two's complement, Q1.(WIDTH-1).
- tw_im, out, WIDTH: twiddle imaginary part, same format.

Function
REQ-003 Sample counter cnt (LOG_M bits) SHALL increment by 1 on each clock with di_en=1, SHALL hold otherwise, and SHALL wrap from M-1 to 0.
REQ-004 Quarter q = cnt[LOG_M-1:LOG_M-2] and index k = cnt[LOG_M-3:0]; multiplier qm SHALL be 0, 2, 1, 3 for q = 0, 1, 2, 3.
REQ-005 Full table address taddr = (k*qm) << (NN-LOG_M), NN bits; the product SHALL never exceed 3*(M/4-1), so no truncation occurs.
REQ-006 Pipeline S1: register taddr and a valid bit from the counter state that holds before the di_en increment.
REQ-007 Pipeline S2: the ROM SHALL read on the S1 address with a registered output; taddr and the valid bit travel alongside.
REQ-008 Pipeline S3: apply octant reconstruction and register tw_re, tw_im, tw_bypass and do_en.
REQ-009 Latency SHALL be exactly 3 cycles from di_en=1 to the matching do_en=1, one output per input, with no bubbles inserted or removed.
REQ-010 ROM content at address a SHALL be round(cos(2*pi*a/N)*2^(WIDTH-1)) and -round(sin(2*pi*a/N)*2^(WIDTH-1)), saturated to WIDTH bits.
REQ-011 taddr=0 SHALL give tw_bypass=1 and tw_re=tw_im=0; every other address SHALL give tw_bypass=0.
REQ-012 When do_en=0, tw_re, tw_im and tw_bypass SHALL hold their last values.
REQ-013 di_en gaps of any length SHALL stall only the counter; in-flight pipeline entries SHALL still drain.

Reset
REQ-014 Assertion of reset SHALL immediately clear cnt, all valid bits, do_en, tw_bypass, tw_re and tw_im to 0.
REQ-015 Reset asserted mid-block SHALL discard all in-flight entries, and the first di_en after release SHALL use cnt=0.

Configuration
REQ-016 Macro TWIDDLE_TAB_REDUCE_EN SHALL select the table implementation:
- Defined: ROM holds N/8+1 entries for addresses 0..N/8 only.
- Defined, ROM address: k' = taddr[NN-4:0], negated when taddr[NN-3]=1.
- Defined, octant mapping for o = taddr[NN-1:NN-3], with (r,i) the ROM output: o=0 gives (r,i); o=1 gives (-i,-r); o=2 gives (i,-r); o=3 gives (-r,i); o=4 gives (-r,-i); o=5 gives (i,r).
- Defined, constants replace the ROM when k'=0: o=1 gives (C,-C); o=2 gives (0,S); o=3 gives (-C,-C); o=4 gives (S,0). Here C = round(cos(pi/4)*2^(WIDTH-1)) and S = -2^(WIDTH-1).
- Undefined: a full N-entry ROM indexed directly by taddr, with no reconstruction logic.
- In both builds, outputs SHALL be bit-identical and latency SHALL be unchanged.

Structure
REQ-017 A shared package SHALL hold the quarter-multiplier table {0,2,1,3}, the constants C and S as functions of WIDTH, and the octant encoding.
REQ-018 One sub-module twiddle_rom SHALL hold the registered ROM: parameters NN, WIDTH and a depth selected by the macro.

Verification
REQ-019 Bench SHALL cover, with NN=6, LOG_M=6, WIDTH=16:
- 64 consecutive di_en after reset: do_en is 1 exactly from cycle 3 to cycle 66; samples 0..15 and 16, 32, 48 give tw_bypass=1.
- Sample 20 (q=1, k=4, taddr=8): tw_re=0x5A82, tw_im=0xA57E.
- Sample 24 (taddr=16): tw_re=0x0000, tw_im=0x8000.
- Sample 52 (taddr=12): ROM-golden values; both macro builds match bit-for-bit across all 64 samples.
- di_en toggled 1,0,0,1 repeatedly: do_en mirrors di_en delayed 3 cycles; the counter reaches 63 and wraps to 0.
- Reset pulsed at sample 37: do_en=0 next cycle; the next sample after release yields tw_bypass=1 (cnt=0).
